// File: rtl/regbank16_wr.sv
// regbank16_wr
//   16-entry x W-bit register bank, write side. Two write ports per cycle
//   (A: ALU result, B: load/writeback) are decoded into one-hot enables.
//   All entries leave the block as one flattened bus feeding the read mux.
//
// Parameters
//   W          data width in bits (>= 1)
//   ZERO_REG   1: entry 0 is hardwired to zero and writes to it are dropped
//   RESET_VAL  value loaded into every entry on reset and on clr
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   clr           synchronous clear of all entries and of written_mask
//   we_a/addr_a/data_a   write port A
//   we_b/addr_b/data_b   write port B (wins on a same-address dual write)
//   regs_flat     all entries, entry k at [k*W +: W]
//   written_mask  bit k set once entry k has been written since reset/clr
//   collision     one-cycle pulse after a same-address dual write
module regbank16_wr #(
   parameter int unsigned    W         = 8,
   parameter bit             ZERO_REG  = 1'b0,
   parameter logic [W-1:0]   RESET_VAL = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            we_a,
   input  logic [3:0]      addr_a,
   input  logic [W-1:0]    data_a,
   input  logic            we_b,
   input  logic [3:0]      addr_b,
   input  logic [W-1:0]    data_b,
   output logic [16*W-1:0] regs_flat,
   output logic [15:0]     written_mask,
   output logic            collision
);

   // Entry 0 is never enabled when hardwired, so it simply keeps its
   // reset value of zero.
   localparam logic [15:0] WR_KEEP = ZERO_REG ? 16'hFFFE : 16'hFFFF;

   logic [W-1:0] regs [16];
   logic [15:0]  wen_a;
   logic [15:0]  wen_b;
   logic         same_addr;

   function automatic logic [W-1:0] init_val(input int unsigned k);
      return (ZERO_REG && (k == 0)) ? '0 : RESET_VAL;
   endfunction

   always_comb begin
      wen_a     = (we_a ? (16'd1 << addr_a) : '0) & WR_KEEP;
      wen_b     = (we_b ? (16'd1 << addr_b) : '0) & WR_KEEP;
      // Raised even for a dropped write to a hardwired entry 0.
      same_addr = we_a & we_b & (addr_a == addr_b);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < 16; k++) regs[k] <= init_val(k);
         written_mask <= '0;
         collision    <= 1'b0;
      end else if (clr) begin
         for (int unsigned k = 0; k < 16; k++) regs[k] <= init_val(k);
         written_mask <= '0;
         collision    <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < 16; k++) begin
            if (wen_b[k])      regs[k] <= data_b;
            else if (wen_a[k]) regs[k] <= data_a;
         end
         written_mask <= written_mask | wen_a | wen_b;
         collision    <= same_addr;
      end
   end

   always_comb begin
      regs_flat = '0;
      for (int unsigned k = 0; k < 16; k++) regs_flat[k*W +: W] = regs[k];
   end

endmodule

// File: doc/regbank16_wr.md
Name: regbank16_wr

Overview:
- 16-entry x W-bit register bank: the write-side counterpart to the 16:1 read mux.
- Decodes up to two write requests per cycle (ALU result port A, load/writeback port B) into one-hot enables.
- Drives all 16 registers as one flattened bus; slot k occupies bits [k*W +: W], so the bus feeds the read mux directly.
- Tracks which entries have been written since reset/clear, for debug and hazard logic.

Parameters:
- W, 8, register data width in bits (>=1).
- ZERO_REG, 0, when 1 entry 0 is hardwired to zero and writes to it are discarded.
- RESET_VAL, 0, W-bit value loaded into every entry on reset and on clear.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of all entries and of written_mask.
- we_a  input  1  write enable, port A.
- addr_a  input  4  target entry, port A.
- data_a  input  W  write data, port A.
- we_b  input  1  write enable, port B.
- addr_b  input  4  target entry, port B.
- data_b  input  W  write data, port B.
- regs_flat  output  16*W  all entries, flattened; entry k at [k*W +: W].
- written_mask  output  16  bit k = 1 once entry k has been written since the last reset/clear.
- collision  output  1  registered; 1 for one cycle after a same-address dual write.

Behaviour:
- Reset: rst_n low asynchronously forces:
  - every entry to RESET_VAL (entry 0 to 0 if ZERO_REG);
  - written_mask = 0;
  - collision = 0.
  - Outputs hold these values while rst_n is low.
- Reset release: deassertion is used as is; no internal synchroniser.
- Latency: a write sampled at rising edge N is visible on regs_flat after edge N. There is no combinational path from data_*/addr_* to regs_flat.
- Decode: each port produces a 16-bit one-hot enable = we_x ? (1 << addr_x) : 0.
- Priority (same cycle):
  1. clr has highest priority: all entries go to RESET_VAL, written_mask to 0, collision to 0, and both write ports are ignored that cycle.
  2. If we_a and we_b target the same address, port B wins. The entry takes data_b, and collision = 1 on the next cycle.
  3. Distinct addresses: both entries are updated in the same edge.
- collision: equals 0 on any edge without a same-address dual write. It is a one-cycle pulse and never sticky.
- written_mask: bit k is set on any accepted write to k, including the port-B-wins case. It is cleared only by reset or clr.
- ZERO_REG = 1:
  - entry 0 always reads 0;
  - writes to addr 0 are discarded and do not set written_mask[0];
  - a same-address dual write to 0 still raises collision.
- ZERO_REG = 0: entry 0 behaves like any other entry.
- Entries not addressed hold their value. No bit of regs_flat changes except the addressed slots.
- Reset mid-operation: an asynchronous assert during a cycle with pending writes discards those writes; state goes to reset values immediately.
- Widths:
  - data is stored unmodified; no sign-extension or truncation;
  - all 4-bit addresses are valid, so there is no out-of-range case.

Test Plan:
- Reset/defaults: W=8, RESET_VAL=8'hA5; assert rst_n=0 mid-cycle -> regs_flat = {16{8'hA5}} immediately, written_mask=0, collision=0.
- Single write and latency: we_a=1, addr_a=3, data_a=8'h3C at edge N -> regs_flat[31:24]=8'h3C after edge N, still A5 before it; written_mask=16'h0008; all other slots unchanged.
- Dual write, distinct addresses: A writes 5<-8'h11, B writes 15<-8'hEE on the same edge -> slots 5 and 15 updated together; written_mask |= 16'h8020; collision=0.
- Same-address conflict: A writes 7<-8'h01, B writes 7<-8'h02 -> slot 7 = 8'h02; collision=1 for exactly one cycle, then 0; written_mask bit 7 set.
- Clear priority: clr=1 with we_a=1, addr_a=2, data_a=8'hFF -> after the edge all slots = 8'hA5, written_mask=0, slot 2 not written.
- ZERO_REG=1: write 0<-8'h77 -> slot 0 stays 0, written_mask[0]=0. Sweep addresses 1..15 with data = addr -> each slot k = k, written_mask=16'hFFFE.
